mc_controller: RTL and testbench
================================

# mc_controller

- Sequencing control unit for the multicycle MIPS datapath.
- Drives the 4-bit ALU function code, operand selects, mux selects and write enables, and consumes the ALU `zero` flag.
- It is the initiator side of the ALU control interface: the ALU is purely combinational; this block decides what it computes each cycle.
- Moore FSM plus a funct decoder, between the instruction register and the datapath.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `op`  in  6  instruction opcode, IR[31:26]
- `funct`  in  6  instruction funct, IR[5:0]
- `zero`  in  1  ALU zero flag, same cycle
- `alucontrol`  out  4  ALU function code: f[2] inverts b and sets carry-in; f[1:0] selects 00 AND, 01 OR, 10 SUM, 11 SLT; f[3] selects unsigned SLT
- `alusrca`  out  1  0 = PC, 1 = register A
- `alusrcb`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `irwrite`  out  1  instruction register load
- `memwrite`  out  1  data memory write
- `regwrite`  out  1  register file write
- `regdst`  out  1  0 = rt, 1 = rd
- `memtoreg`  out  1  0 = ALUOut, 1 = memory data
- `pcen`  out  1  PC load enable
- `retire`  out  1  high in the last cycle of each instruction

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.

Transitions:
- FETCH→DECODE.
- DECODE, by op:
  - 100011/101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other op → FETCH, executed as a NOP
- MEMADR→MEMRD (lw) or MEMWR (sw).
- MEMRD→MEMWB.
- RTYPEEX→RTYPEWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.

Outputs are decoded from the state; unlisted outputs are 0, and `alucontrol` defaults to 0010:
- FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, `alucontrol`=0010.
- DECODE: `alusrcb`=11, `alucontrol`=0010 (branch target).
- MEMADR / ADDIEX: `alusrca`=1, `alusrcb`=10, `alucontrol`=0010.
- MEMRD: `iord`=1.
- MEMWB: `regwrite`=1, `memtoreg`=1.
- MEMWR: `iord`=1, `memwrite`=1.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` decoded from funct:
  - 100000 → 0010
  - 100010 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 101010 → 0111
  - 101011 → 1111
  - other → 0010
- RTYPEWB: `regwrite`=1, `regdst`=1.
- ADDIWB: `regwrite`=1.
- BEQEX: `alusrca`=1, `alusrcb`=00, `alucontrol`=0110, `pcsrc`=01, `branch`=1.
- JEX: `pcsrc`=10, `pcwrite`=1.

PC enable and retire:
- `pcen` = `pcwrite` | (`branch` & `zero`). `pcwrite` and `branch` are internal.
- `retire` is high in MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX, and in DECODE when the op is unsupported.

## Timing
- The state register updates on the rising edge of `clk`; all outputs are combinational from the state, plus `funct`/`op` in RTYPEEX/DECODE and `zero` in BEQEX.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - unsupported op 2
- Reset:
  - If `reset` is high at an edge, the state becomes FETCH.
  - While `reset` is high, `memwrite`, `regwrite`, `irwrite`, `pcen` and `retire` are forced to 0, regardless of state.
  - After reset, the first cycle with `reset` low is FETCH, with `irwrite`=1 and `pcen`=1.
- Reset mid-instruction (e.g. in MEMWR) suppresses that cycle's write; no partial retire is signalled.
- The `zero` input is used only in BEQEX (and in BNEEX when enabled); in all other states it is ignored.
- No state is unreachable from reset. An illegal state encoding returns to FETCH on the next edge.

## Configuration
- `MC_CTRL_BNE_EN` defined:
  - Adds state BNEEX, entered from DECODE on op 000101.
  - BNEEX outputs match BEQEX, with internal `nbranch`=1 in place of `branch`.
  - `pcen` gains the term | (`nbranch` & ~`zero`).
  - BNEEX→FETCH; BNEEX raises `retire`.
- Undefined: op 000101 is unsupported and handled as a 2-cycle NOP.

## Test plan
- Reset: hold `reset` high 2 cycles, then release → first cycle is FETCH with `irwrite`=1, `pcen`=1, `alucontrol`=0010, `alusrcb`=01; `memwrite`=`regwrite`=0.
- lw: op=100011 → 5 cycles. MEMADR has `alusrcb`=10. MEMRD has `iord`=1. MEMWB has `regwrite`=1, `memtoreg`=1, `retire`=1. Then FETCH.
- R-type funct sweep: op=000000 with funct 100010/101010/101011 → RTYPEEX `alucontrol` = 0110/0111/1111. RTYPEWB has `regdst`=1, `regwrite`=1.
- beq: op=000100 with `zero`=1 → BEQEX `pcen`=1, `pcsrc`=01. Repeat with `zero`=0 → `pcen`=0. Both return to FETCH after 3 cycles.
- Unsupported op 111111 → DECODE `retire`=1, then FETCH; no write enable asserted in either cycle.
- Reset asserted during MEMWR (sw) → `memwrite`=0 in that cycle, FETCH on the next cycle after release. With `MC_CTRL_BNE_EN`: op=000101, `zero`=0 → `pcen`=1.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS sequencing controller: Moore FSM plus funct decoder driving the datapath.
// Latency: outputs are combinational from the state (op/funct/zero fold in where needed); one state per clock.
// No backpressure; MC_CTRL_BNE_EN adds a bne state (op 000101), otherwise bne executes as a NOP.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       pcen,
    output logic       retire
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MC_CTRL_BNE_EN
        , S_BNEEX = 4'd12
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [3:0] w_funct_alu;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_nbranch;
    logic       w_retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        case (funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            6'b101011: w_funct_alu = ALU_SLTU;
            default:   w_funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_next     = S_FETCH;
        alucontrol = ALU_ADD;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_nbranch  = 1'b0;
        w_retire   = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BNEEX;
`endif
                    default: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_RTYPEEX: begin
                w_next     = S_RTYPEWB;
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
            end
            S_RTYPEWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
                w_retire   = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
                w_retire   = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_nbranch  = 1'b1;
                w_retire   = 1'b1;
            end
`endif
            S_ADDIEX: begin
                w_next  = S_ADDIWB;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_retire  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every architectural side effect, including one interrupted mid-instruction
    assign irwrite  = w_irwrite  & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign retire   = w_retire   & ~reset;
    assign pcen     = (w_pcwrite | (w_branch & zero) | (w_nbranch & ~zero)) & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle compare of the full control word against hand-written vectors.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, retire;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .alucontrol (alucontrol),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .pcen       (pcen),
        .retire     (retire)
    );

    // {alucontrol, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, retire}
    logic [16:0] w_ctl;
    assign w_ctl = {alucontrol, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
                    regwrite, regdst, memtoreg, pcen, retire};

    localparam logic [16:0] E_FETCH     = {4'b0010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_FETCH_RST = {4'b0010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DECODE    = {4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DEC_NOP   = {4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_MEMADR    = {4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMRD     = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMWB     = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [16:0] E_MEMWR     = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_MEMWR_RST = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_RTYPEWB   = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_ADDIWB    = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_BR_TAKEN  = {4'b0110, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [16:0] E_BR_NOT    = {4'b0110, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_JEX       = {4'b0010, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Every scenario task starts in the first half of a FETCH cycle, with inputs driven at posedge+1.

    task automatic test_reset;
        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (w_ctl !== E_FETCH_RST) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", w_ctl, E_FETCH_RST);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (w_ctl !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release_fetch: got %b want %b", w_ctl, E_FETCH);
        end
    endtask

    task automatic test_lw;
        logic [16:0] exp [5];
        exp   = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        op    = 6'b100011;
        funct = 6'b100010;
        zero  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw;
        logic [16:0] exp [4];
        exp  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        op   = 6'b101011;
        zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype;
        logic [5:0]  fn  [6];
        logic [3:0]  alu [6];
        logic [16:0] exp [4];
        fn  = '{6'b100010, 6'b101010, 6'b101011, 6'b100100, 6'b100101, 6'b000111};
        alu = '{4'b0110,   4'b0111,   4'b1111,   4'b0000,   4'b0001,   4'b0010};
        op   = 6'b000000;
        zero = 1'b1;
        for (int t = 0; t < 6; t++) begin
            funct = fn[t];
            exp = '{E_FETCH, E_DECODE, {alu[t], 1'b1, 2'b00, 2'b00, 8'b0000_0000}, E_RTYPEWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (w_ctl !== exp[i]) begin
                    errors++;
                    $display("FAIL rtype funct=%b cycle %0d: got %b want %b", fn[t], i, w_ctl, exp[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_beq;
        logic [16:0] exp [3];
        op = 6'b000100;
        for (int t = 0; t < 2; t++) begin
            zero = (t == 0);
            exp  = '{E_FETCH, E_DECODE, (t == 0) ? E_BR_TAKEN : E_BR_NOT};
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (w_ctl !== exp[i]) begin
                    errors++;
                    $display("FAIL beq zero=%0d cycle %0d: got %b want %b", zero, i, w_ctl, exp[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_unsupported;
        logic [16:0] exp [2];
        exp  = '{E_FETCH, E_DEC_NOP};
        op   = 6'b111111;
        zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL unsupported cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi;
        logic [16:0] exp [4];
        exp  = '{E_FETCH, E_DECODE, E_MEMADR, E_ADDIWB};
        op   = 6'b001000;
        zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL addi cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne;
`ifdef MC_CTRL_BNE_EN
        logic [16:0] exp [3];
        exp = '{E_FETCH, E_DECODE, E_BR_TAKEN};
`else
        logic [16:0] exp [2];
        exp = '{E_FETCH, E_DEC_NOP};
`endif
        op   = 6'b000101;
        zero = 1'b0;
        for (int i = 0; i < $size(exp); i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL bne cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sw;
        logic [16:0] exp [3];
        exp  = '{E_FETCH, E_DECODE, E_MEMADR};
        op   = 6'b101011;
        zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL sw_reset cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (w_ctl !== E_MEMWR_RST) begin
            errors++;
            $display("FAIL sw_reset memwr_masked: got %b want %b", w_ctl, E_MEMWR_RST);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (w_ctl !== E_FETCH) begin
            errors++;
            $display("FAIL sw_reset fetch_after: got %b want %b", w_ctl, E_FETCH);
        end
    endtask

    task automatic test_jump;
        logic [16:0] exp [4];
        exp  = '{E_FETCH, E_DECODE, E_JEX, E_FETCH};
        op   = 6'b000010;
        zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (w_ctl !== exp[i]) begin
                errors++;
                $display("FAIL jump cycle %0d: got %b want %b", i, w_ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_unsupported();
        test_addi();
        test_bne();
        test_reset_mid_sw();
        test_jump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
